// File: rtl/cbus_ram_responder.sv
// On-chip 64-bit RAM terminating cbus bursts (INCR/FIXED/WRAP),
// with programmable first-beat latency and byte-strobed writes.
package cbus_pkg;
   localparam logic [1:0] BURST_FIXED = 2'd0;
   localparam logic [1:0] BURST_INCR  = 2'd1;
   localparam logic [1:0] BURST_WRAP  = 2'd2;
   localparam logic [2:0] MSIZE8      = 3'd3;
   localparam logic [3:0] MLEN16      = 4'd15;

   typedef struct packed {
      logic        valid;
      logic        is_write;
      logic [2:0]  size;
      logic [31:0] addr;
      logic [7:0]  strobe;
      logic [63:0] data;
      logic [3:0]  len;
      logic [1:0]  burst;
   } cbus_req_t;

   typedef struct packed {
      logic        ready;
      logic        last;
      logic [63:0] data;
   } cbus_resp_t;
endpackage

module cbus_ram_responder
   import cbus_pkg::*;
#(
   parameter int ADDR_WIDTH = 16,
   parameter int LATENCY    = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  cbus_req_t  creq,
   output cbus_resp_t cresp
);
   localparam int CW = ADDR_WIDTH + 3;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST} state_t;

   state_t          state_q, state_d;
   logic [3:0]      wait_q, wait_d;
   logic [3:0]      beat_q, beat_d;
   logic [3:0]      len_q, len_d;
   logic [2:0]      size_q, size_d;
   logic [1:0]      burst_q, burst_d;
   logic            wr_q, wr_d;
   logic [CW-1:0]   cur_q, cur_d;

   logic [63:0]     mem [0:(1<<ADDR_WIDTH)-1];
   logic [ADDR_WIDTH-1:0] word;
   logic [4:0]      nbeats;
   logic            pow2;
   logic [CW-1:0]   step, bound, mask, incr, nxt;
   logic            busy, we;
   logic            unused_addr;

   assign unused_addr = ^creq.addr[31:CW];
   assign word   = cur_q[CW-1:3];
   assign nbeats = {1'b0, len_q} + 5'd1;
   assign pow2   = (nbeats & {1'b0, len_q}) == 5'd0;
   assign step   = CW'(1) << size_q;
   assign bound  = CW'(nbeats) << size_q;
   assign mask   = bound - CW'(1);
   assign incr   = cur_q + step;

   // Non power-of-two wrap lengths degrade to INCR
   always_comb begin
      nxt = incr;
      unique case (1'b1)
         (burst_q == BURST_FIXED):        nxt = cur_q;
         (burst_q == BURST_WRAP && pow2): nxt = (cur_q & ~mask) | (incr & mask);
         default:                         nxt = incr;
      endcase
   end

   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      beat_d  = beat_q;
      len_d   = len_q;
      size_d  = size_q;
      burst_d = burst_q;
      wr_d    = wr_q;
      cur_d   = cur_q;
      case (state_q)
         S_IDLE: begin
            if (creq.valid) begin
               len_d   = creq.len;
               size_d  = creq.size;
               burst_d = creq.burst;
               wr_d    = creq.is_write;
               cur_d   = creq.addr[CW-1:0];
               beat_d  = 4'd0;
               wait_d  = 4'(LATENCY);
               state_d = (LATENCY == 0) ? S_BURST : S_WAIT;
            end
         end
         S_WAIT: begin
            if (!creq.valid) begin
               state_d = S_IDLE;
            end else begin
               wait_d = wait_q - 4'd1;
               if (wait_q <= 4'd1) state_d = S_BURST;
            end
         end
         S_BURST: begin
            if (!creq.valid) begin
               state_d = S_IDLE;
            end else begin
               beat_d = beat_q + 4'd1;
               cur_d  = nxt;
               if (beat_q == len_q) state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         wait_q  <= 4'd0;
         beat_q  <= 4'd0;
         len_q   <= 4'd0;
         size_q  <= 3'd0;
         burst_q <= 2'd0;
         wr_q    <= 1'b0;
         cur_q   <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         beat_q  <= beat_d;
         len_q   <= len_d;
         size_q  <= size_d;
         burst_q <= burst_d;
         wr_q    <= wr_d;
         cur_q   <= cur_d;
      end
   end

   assign busy = (state_q == S_BURST);
   assign we   = busy && wr_q && creq.valid && !reset;

   // Memory is deliberately left untouched by reset
   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < 8; i++) begin
            if (creq.strobe[i]) mem[word][i*8 +: 8] <= creq.data[i*8 +: 8];
         end
      end
   end

   always_comb begin
      cresp.ready = busy;
      cresp.last  = busy && (beat_q == len_q);
      cresp.data  = busy ? mem[word] : 64'd0;
   end
endmodule

// File: tb/tb_cbus_ram_responder.sv
// Directed bench for cbus_ram_responder: latency, bursts,
// strobes, wrap order, abort/reset and zero-latency turnaround.
module tb_cbus_ram_responder;
   import cbus_pkg::*;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   cbus_req_t  req_a, req_b;
   cbus_resp_t resp_a, resp_b;

   int checks = 0;
   int errors = 0;

   logic [63:0] wd [16];
   logic [7:0]  ws [16];
   logic [63:0] rx [16];

   always #5 clk = ~clk;

   cbus_ram_responder #(.ADDR_WIDTH(16), .LATENCY(2)) dut_a (
      .clk(clk), .reset(reset), .creq(req_a), .cresp(resp_a)
   );

   cbus_ram_responder #(.ADDR_WIDTH(8), .LATENCY(0)) dut_b (
      .clk(clk), .reset(reset), .creq(req_b), .cresp(resp_b)
   );

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic cbus_resp_t rsp(input bit s);
      return s ? resp_b : resp_a;
   endfunction

   task automatic drive(input bit s, input cbus_req_t r);
      if (s) req_b = r;
      else   req_a = r;
   endtask

   task automatic burst(input bit sel, input bit wr,
                        input logic [31:0] addr, input logic [3:0] len,
                        input logic [1:0] bt, input int exp_lat,
                        input int stop_at, input bit use_rst,
                        input bit chk_rd, input string nm);
      cbus_req_t r;
      int n;
      r          = '0;
      r.valid    = 1'b1;
      r.is_write = wr;
      r.size     = MSIZE8;
      r.addr     = addr;
      r.len      = len;
      r.burst    = bt;
      r.data     = wd[0];
      r.strobe   = ws[0];
      drive(sel, r);
      n = 0;
      do begin
         tick();
         n++;
      end while (!rsp(sel).ready && n < 20);
      chk($sformatf("%s_latency", nm), 64'(n), 64'(exp_lat));
      if (!rsp(sel).ready) begin
         r.valid = 1'b0;
         drive(sel, r);
         tick();
         return;
      end
      for (int k = 0; k <= int'(len); k++) begin
         r.data   = wd[k];
         r.strobe = ws[k];
         if (k == stop_at) begin
            if (use_rst) reset = 1'b1;
            else         r.valid = 1'b0;
         end
         drive(sel, r);
         chk($sformatf("%s_ready%0d", nm, k), 64'(rsp(sel).ready), 64'd1);
         chk($sformatf("%s_last%0d", nm, k), 64'(rsp(sel).last),
             64'(k == int'(len)));
         if (!wr && chk_rd)
            chk($sformatf("%s_data%0d", nm, k), rsp(sel).data, rx[k]);
         tick();
         if (k == stop_at) begin
            chk($sformatf("%s_stop_ready", nm), 64'(rsp(sel).ready), 64'd0);
            reset   = 1'b0;
            r.valid = 1'b0;
            drive(sel, r);
            tick();
            chk($sformatf("%s_stop_idle", nm), 64'(rsp(sel).ready), 64'd0);
            return;
         end
      end
      r.valid = 1'b0;
      drive(sel, r);
      chk($sformatf("%s_end_ready", nm), 64'(rsp(sel).ready), 64'd0);
      chk($sformatf("%s_end_data", nm), rsp(sel).data, 64'd0);
   endtask

   initial begin
      cbus_req_t r;
      req_a = '0;
      req_b = '0;
      for (int k = 0; k < 16; k++) begin
         ws[k] = 8'hFF;
         wd[k] = 64'd0;
         rx[k] = 64'd0;
      end

      // reset held with a pending request: outputs stay quiet
      r = '0;
      r.valid = 1'b1;
      r.size  = MSIZE8;
      req_a   = r;
      for (int c = 0; c < 3; c++) begin
         tick();
         chk($sformatf("rst_ready%0d", c), 64'(resp_a.ready), 64'd0);
         chk($sformatf("rst_last%0d", c), 64'(resp_a.last), 64'd0);
         chk($sformatf("rst_data%0d", c), resp_a.data, 64'd0);
      end
      reset = 1'b0;
      burst(0, 0, 32'h0, 4'd0, BURST_INCR, 3, -1, 0, 0, "post_rst");

      // line fill preload then 16-beat read
      for (int k = 0; k < 16; k++) begin
         wd[k] = 64'h100 + 64'(k);
         rx[k] = 64'h100 + 64'(k);
      end
      burst(0, 1, 32'h800, MLEN16, BURST_INCR, 3, -1, 0, 0, "fill_wr");
      burst(0, 0, 32'h800, MLEN16, BURST_INCR, 3, -1, 0, 1, "fill_rd");

      // strobed write over a known background
      for (int k = 0; k < 4; k++) wd[k] = 64'h5555_5555_5555_5555;
      burst(0, 1, 32'h40, 4'd3, BURST_INCR, 3, -1, 0, 0, "bg_wr");
      for (int k = 0; k < 4; k++) wd[k] = 64'hAAAA_AAAA_AAAA_AAAA;
      ws[1] = 8'h0F;
      burst(0, 1, 32'h40, 4'd3, BURST_INCR, 3, -1, 0, 0, "strb_wr");
      ws[1] = 8'hFF;
      rx[0] = 64'hAAAA_AAAA_AAAA_AAAA;
      rx[1] = 64'h5555_5555_AAAA_AAAA;
      rx[2] = 64'hAAAA_AAAA_AAAA_AAAA;
      rx[3] = 64'hAAAA_AAAA_AAAA_AAAA;
      burst(0, 0, 32'h40, 4'd3, BURST_INCR, 3, -1, 0, 1, "strb_rd");

      // wrap / fixed / non power-of-two wrap
      for (int k = 0; k < 4; k++) wd[k] = 64'hA0 + 64'(k);
      burst(0, 1, 32'h0, 4'd3, BURST_INCR, 3, -1, 0, 0, "wrap_pre");
      rx[0] = 64'hA3; rx[1] = 64'hA0; rx[2] = 64'hA1; rx[3] = 64'hA2;
      burst(0, 0, 32'h18, 4'd3, BURST_WRAP, 3, -1, 0, 1, "wrap_rd");
      for (int k = 0; k < 4; k++) rx[k] = 64'hA3;
      burst(0, 0, 32'h18, 4'd3, BURST_FIXED, 3, -1, 0, 1, "fixed_rd");
      rx[0] = 64'hA1; rx[1] = 64'hA2; rx[2] = 64'hA3;
      burst(0, 0, 32'h08, 4'd2, BURST_WRAP, 3, -1, 0, 1, "wrap3_rd");

      // abort by dropping valid at beat index 5
      for (int k = 0; k < 16; k++) wd[k] = 64'h1111_0000 + 64'(k);
      burst(0, 1, 32'h1000, MLEN16, BURST_INCR, 3, -1, 0, 0, "ab_pre");
      for (int k = 0; k < 16; k++) wd[k] = 64'hBEEF_0000 + 64'(k);
      burst(0, 1, 32'h1000, MLEN16, BURST_INCR, 3, 5, 0, 0, "ab_wr");
      for (int k = 0; k < 16; k++)
         rx[k] = (k < 5) ? 64'hBEEF_0000 + 64'(k) : 64'h1111_0000 + 64'(k);
      burst(0, 0, 32'h1000, MLEN16, BURST_INCR, 3, -1, 0, 1, "ab_rd");

      // same, but reset lands on beat index 5
      for (int k = 0; k < 16; k++) wd[k] = 64'h1111_0000 + 64'(k);
      burst(0, 1, 32'h1800, MLEN16, BURST_INCR, 3, -1, 0, 0, "rs_pre");
      for (int k = 0; k < 16; k++) wd[k] = 64'hBEEF_0000 + 64'(k);
      burst(0, 1, 32'h1800, MLEN16, BURST_INCR, 3, 5, 1, 0, "rs_wr");
      burst(0, 0, 32'h1800, MLEN16, BURST_INCR, 3, -1, 0, 1, "rs_rd");

      // zero latency: back-to-back single-beat reads
      wd[0] = 64'h11;
      wd[1] = 64'h22;
      burst(1, 1, 32'h0, 4'd1, BURST_INCR, 1, -1, 0, 0, "l0_wr");
      rx[0] = 64'h11;
      burst(1, 0, 32'h0, 4'd0, BURST_INCR, 1, -1, 0, 1, "l0_rd0");
      rx[0] = 64'h22;
      burst(1, 0, 32'h8, 4'd0, BURST_INCR, 1, -1, 0, 1, "l0_rd1");
      tick();
      chk("l0_idle", 64'(resp_b.ready), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
